// File: rtl/banked_mem_ctrl_pkg.sv
// Shared constants and types for the four-bank memory controller.
// Bank field sits just above the halfword bit; row field follows.
package banked_mem_ctrl_pkg;

    localparam int NUM_BANKS   = 4;
    localparam int BANK_W      = 2;
    localparam int BUSY_CYCLES = 4;
    localparam int CNT_W       = 3;
    localparam int RD_LAT      = 2;
    localparam int BANK_LSB    = 1;
    localparam int BANK_MSB    = 2;
    localparam int ROW_LSB     = 3;

    typedef struct packed {
        logic              vld;
        logic [BANK_W-1:0] bank;
    } rd_stage_t;

    function automatic logic [BANK_W-1:0] bank_of(input logic [15:0] a);
        return a[BANK_MSB:BANK_LSB];
    endfunction

endpackage

// File: rtl/bank_busy_timer.sv
// Per-bank occupancy timer: reloads on accept, busy while count is nonzero.
import banked_mem_ctrl_pkg::*;

module bank_busy_timer (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic busy_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(BUSY_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/banked_mem_ctrl.sv
// Four-bank halfword memory with per-bank busy windows and a
// two-stage read pipeline returning data two cycles after accept.
import banked_mem_ctrl_pkg::*;

module banked_mem_ctrl #(
    parameter int ROW_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [15:0]          addr,
    input  logic [15:0]          data_in,
    output logic [15:0]          data_out,
    output logic                 valid_out,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 stall,
    output logic                 err
);

    localparam int DEPTH = NUM_BANKS << ROW_W;

    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic              req;
    logic              accept;

    logic [15:0] mem_q [DEPTH];

    rd_stage_t         s1_q;
    rd_stage_t         s1_d;
    logic [ROW_W-1:0]  s1_row_q;
    logic              vld_q;
    logic [15:0]       data_q;

    logic unused_addr;

    assign bank = bank_of(addr);
    assign row  = addr[ROW_LSB+ROW_W-1:ROW_LSB];
    assign unused_addr = ^addr[15:ROW_LSB+ROW_W];

    assign req    = rd ^ wr;
    assign err    = (rd & wr) | ((rd | wr) & addr[0]);
    assign stall  = req & ~err & busy[bank];
    assign accept = req & ~err & ~busy[bank] & ~rst;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        bank_busy_timer u_timer (
            .clk    (clk),
            .rst    (rst),
            .load_i (accept && (bank == BANK_W'(i))),
            .busy_o (busy[i])
        );
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem_q[{bank, row}] <= data_in;
        end
    end

    always_comb begin
        s1_d      = '0;
        s1_d.vld  = accept & rd;
        s1_d.bank = bank;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s1_row_q <= '0;
            vld_q    <= 1'b0;
            data_q   <= 16'h0000;
        end else begin
            s1_q     <= s1_d;
            s1_row_q <= row;
            vld_q    <= s1_q.vld;
            if (s1_q.vld) begin
                data_q <= mem_q[{s1_q.bank, s1_row_q}];
            end
        end
    end

    assign valid_out = vld_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Self-checking bench for banked_mem_ctrl: directed scenarios plus
// random traffic against a cycle-indexed behavioural model.
module tb_banked_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        valid_out;
    logic [3:0]  busy;
    logic        stall;
    logic        err;

    banked_mem_ctrl #(.ROW_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .stall     (stall),
        .err       (err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // Model: bank busy until cycle bend[b]; reads due at a given cycle.
    int          bend [4];
    logic [15:0] mmem [int];
    logic [16:0] rdue [int];
    logic [15:0] last_data = 16'h0000;
    logic        last_known = 1'b1;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic rs);
        logic [3:0] eb;
        logic       ee;
        logic       es;
        logic       acc;
        logic       ev;
        int         b;
        int         idx;
        @(posedge clk);
        #1;
        rst = rs;
        rd = r;
        wr = w;
        addr = a;
        data_in = d;
        cyc++;
        if (rs) begin
            for (int k = 0; k < 4; k++) bend[k] = -100;
            rdue.delete();
            last_data = 16'h0000;
            last_known = 1'b1;
        end
        for (int k = 0; k < 4; k++) eb[k] = (cyc <= bend[k]);
        b   = int'(a[2:1]);
        idx = b * 256 + int'((a >> 3) & 16'h00FF);
        ee  = (r & w) | ((r | w) & a[0]);
        es  = (r ^ w) & ~ee & eb[b];
        acc = (r ^ w) & ~ee & ~eb[b] & ~rs;
        ev  = rdue.exists(cyc);
        @(negedge clk);
        chk("busy", 16'(busy), 16'(eb));
        chk("stall", 16'(stall), 16'(es));
        chk("err", 16'(err), 16'(ee));
        chk("valid_out", 16'(valid_out), 16'(ev));
        if (ev) begin
            last_known = rdue[cyc][16];
            last_data = rdue[cyc][15:0];
            if (last_known) chk("rd_data", data_out, last_data);
            rdue.delete(cyc);
        end else if (last_known) begin
            chk("data_hold", data_out, last_data);
        end
        if (acc) begin
            bend[b] = cyc + 4;
            if (w) mmem[idx] = d;
            if (r) begin
                if (mmem.exists(idx)) rdue[cyc + 2] = {1'b1, mmem[idx]};
                else rdue[cyc + 2] = 17'h0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        int op;
        logic [15:0] a;
        for (int k = 0; k < 4; k++) bend[k] = -100;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_data", data_out, 16'h0000);
        idle(2);

        // Write then read back after the bank frees up.
        step(1'b0, 1'b1, 16'h0004, 16'hBEEF, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0);
        idle(2);
        chk("beef_valid", 16'(valid_out), 16'h1);
        chk("beef_data", data_out, 16'hBEEF);
        idle(2);

        // Same-bank back-to-back write stalls through N+4.
        step(1'b0, 1'b1, 16'h0002, 16'h1111, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 16'h0012, 16'h2222, 1'b0);
            chk("same_bank_stall", 16'(stall), 16'h1);
        end
        step(1'b0, 1'b1, 16'h0012, 16'h2222, 1'b0);
        chk("same_bank_accept", 16'(stall), 16'h0);
        idle(5);

        // Four banks read back to back.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 16'(2 * i), 16'(16'hA000 + i), 1'b0);
        idle(5);
        step(1'b1, 1'b0, 16'h0000, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0);
        chk("pipe0", data_out, 16'hA000);
        step(1'b1, 1'b0, 16'h0006, 16'h0, 1'b0);
        chk("pipe1", data_out, 16'hA001);
        idle(1);
        chk("all_busy", 16'(busy), 16'h000F);
        chk("pipe2", data_out, 16'hA002);
        idle(1);
        chk("pipe3", data_out, 16'hA003);
        idle(1);
        chk("pipe_end", 16'(valid_out), 16'h0);
        idle(4);

        // Illegal requests.
        step(1'b1, 1'b1, 16'h0004, 16'h0, 1'b0);
        chk("err_rdwr", 16'(err), 16'h1);
        step(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0);
        chk("err_odd", 16'(err), 16'h1);
        idle(2);
        chk("err_no_busy", 16'(busy), 16'h0);

        // Reset drops an in-flight read.
        step(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        chk("rst_mid_busy", 16'(busy), 16'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("rst_no_valid", 16'(valid_out), 16'h0);
        end

        for (int i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 19);
            a = 16'($urandom_range(0, 65535));
            a[10:3] = 8'($urandom_range(0, 7));
            a[0] = 1'b0;
            if (op < 8) begin
                step(1'b1, 1'b0, a, 16'h0, 1'b0);
            end else if (op < 16) begin
                step(1'b0, 1'b1, a, 16'($urandom_range(0, 65535)), 1'b0);
            end else if (op < 18) begin
                step(1'b0, 1'b0, a, 16'h0, 1'b0);
            end else if (op == 18) begin
                step(1'b1, 1'b1, a, 16'h0, 1'b0);
            end else begin
                a[0] = 1'b1;
                step(1'b1, 1'b0, a, 16'h0, 1'b0);
            end
        end
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/banked_mem_ctrl.md
BANKED_MEM_CTRL -- requirements
Module: banked_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ROW_W, default 8, meaning row-index width per bank (depth 2^ROW_W words per bank).
REQ-002 The block SHALL have input clk, 1 bit: clock, all state on rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have input rd, 1 bit: read request from the cache controller.
REQ-005 The block SHALL have input wr, 1 bit: write request from the cache controller.
REQ-006 The block SHALL have input addr, 16 bits: byte address; bank = addr[2:1], row = addr[3+ROW_W-1:3].
REQ-007 The block SHALL have input data_in, 16 bits: write data.
REQ-008 The block SHALL have output data_out, 16 bits: read data.
REQ-009 The block SHALL have output valid_out, 1 bit: data_out valid, one-cycle pulse.
REQ-010 The block SHALL have output busy, 4 bits: per-bank busy flag, bit i = bank i.
REQ-011 The block SHALL have output stall, 1 bit: request rejected because the target bank is busy.
REQ-012 The block SHALL have output err, 1 bit: illegal request.

Function
REQ-013 The block SHALL accept a request in cycle N iff exactly one of rd/wr is high, addr[0]=0, and busy[bank]=0.
REQ-014 The block SHALL drive err combinationally high when (rd & wr), or when (rd | wr) with addr[0]=1; no access, no busy change.
REQ-015 The block SHALL drive stall combinationally as (rd ^ wr) & ~err & busy[bank]; a stalled request has no side effects.
REQ-016 On an accepted write, the block SHALL update the addressed word at the rising edge ending cycle N.
REQ-017 On an accepted read, the block SHALL capture bank/row at the edge ending cycle N and present the word on data_out with valid_out=1 during cycle N+2 only.
REQ-018 The read path SHALL be a 2-stage valid/bank/row pipeline; reads to different banks accepted in consecutive cycles SHALL produce valid_out in consecutive cycles, in issue order.
REQ-019 Read data SHALL reflect every write accepted before the read's acceptance edge.
REQ-020 An accepted access SHALL set busy[bank]=1 for cycles N+1 through N+4 inclusive; busy[bank]=0 again in N+5.
REQ-021 Each bank SHALL time out independently; any mix of banks may be busy simultaneously.
REQ-022 A request to a bank in its final busy cycle (N+4) SHALL stall; the same request in N+5 SHALL be accepted.
REQ-023 data_out SHALL hold its last value when valid_out=0.
REQ-024 Requests with rd=wr=0 SHALL have no effect; stall=err=0.

Reset
REQ-025 While rst=1: busy=4'b0000, valid_out=0, data_out=16'h0000, read pipeline valids cleared; stall/err follow REQ-014/015 with busy=0.
REQ-026 A read in flight when rst asserts SHALL be dropped; no valid_out after rst deasserts.
REQ-027 Memory array contents SHALL NOT be reset.

Structure
REQ-028 A shared package SHALL hold NUM_BANKS=4, BUSY_CYCLES=4, RD_LAT=2, and the bank-field bit positions.
REQ-029 Per-bank busy timing SHALL be a sub-module bank_busy_timer (load on accept, 3-bit down-counter, busy = count != 0), instantiated NUM_BANKS times.

Verification
REQ-030 Write addr 16'h0004, data 16'hBEEF; after busy[2] clears, read 16'h0004 -> valid_out in N+2, data_out=16'hBEEF.
REQ-031 Write 16'h0002, then write 16'h0012 next cycle (same bank 1) -> second request stall=1 for cycles N+1..N+4, accepted in N+5.
REQ-032 Reads to 16'h0000, 16'h0002, 16'h0004, 16'h0006 on 4 consecutive cycles -> 4 consecutive valid_out pulses in order; busy=4'b1111 in cycle N+4.
REQ-033 rd=wr=1, and separately rd=1 with addr=16'h0003 -> err=1, busy unchanged, no valid_out.
REQ-034 Accept read, assert rst in cycle N+1 -> busy=0 immediately, no valid_out in N+2 or later.
REQ-035 Random mixed traffic against a reference array model -> every valid_out matches the model, no access to a busy bank.
